// File: rtl/csa_reconfig_ctrl.sv
// csa_reconfig_ctrl: built-in self-test and reconfiguration controller for the
// fault-tolerant 7-bit carry-select adder datapath. Sweeps 4-bit patterns into
// the testable conditional-sum cells (units 0, 2, 4), compares each 6-bit response
// against an external golden ROM and accumulates a per-unit fault mask. It then
// maps the mask to input-select/output-select codes that steer around bad cells.
// Optional feature: define CSA_AUTO_RETEST_EN to launch a run on the first cycle
// after reset and again after every RETEST_PERIOD idle cycles.
module csa_reconfig_ctrl #(
  parameter int          NUM_PAT = 16,
  parameter int          SETTLE  = 1,
  parameter logic [13:0] CFG_000 = 14'h3F00,
  parameter logic [13:0] CFG_001 = 14'h1F11,
  parameter logic [13:0] CFG_010 = 14'h2E33,
  parameter logic [13:0] CFG_100 = 14'h3C77,
  parameter logic [13:0] CFG_011 = 14'h0E3B,
  parameter logic [13:0] CFG_101 = 14'h1C7F,
  parameter logic [13:0] CFG_110 = 14'h2C7E
`ifdef CSA_AUTO_RETEST_EN
  ,
  parameter int          RETEST_PERIOD = 1000000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [29:0] actual_output,
  input  logic [5:0]  exp_resp,
  output logic [3:0]  pat_idx,
  output logic        test,
  output logic [3:0]  test_data,
  output logic [2:0]  is0,
  output logic [2:0]  is1,
  output logic [3:0]  ss0,
  output logic [3:0]  ss1,
  output logic [2:0]  fault,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_COMPARE,
    ST_DECIDE,
    ST_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'(NUM_PAT - 1);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t      state_reg, state_next;
  logic [3:0]  pat_idx_reg;
  logic [3:0]  test_data_reg;
  logic        test_reg;
  logic [3:0]  settle_cnt_reg;
  logic [2:0]  mask_reg;
  logic [2:0]  fault_reg;
  logic [13:0] cfg_reg, cfg_next;
  logic        busy_reg;
  logic        done_reg;
  logic        err_reg;
  logic [2:0]  miss;
  logic        launch;
  logic        last_pat;

  // Units 1 and 3 are not testable cells; their responses are deliberately ignored.
  logic unused_slices;
  assign unused_slices = ^{actual_output[11:6], actual_output[23:18]};

  // Per testable unit: mismatch of its 6-bit response against the golden value.
  // Mask bit gi corresponds to datapath unit 2*gi.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unit
      assign miss[gi] = (actual_output[12*gi +: 6] != exp_resp);
    end
  endgenerate

  assign last_pat = (pat_idx_reg == LAST_IDX);

`ifdef CSA_AUTO_RETEST_EN
  logic [19:0] idle_cnt_reg;
  logic        first_reg;

  // Automatic launch: once right after reset, then after RETEST_PERIOD idle cycles.
  // An explicit start in the same cycle merges into the same single launch.
  assign launch = start ||
                  ((state_reg == ST_IDLE) &&
                   (first_reg || (idle_cnt_reg == 20'(RETEST_PERIOD - 1))));

  // Idle-cycle counter; only counts while waiting in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_reg <= '0;
      first_reg    <= 1'b1;
    end else begin
      first_reg <= 1'b0;
      if ((state_reg != ST_IDLE) || launch)
        idle_cnt_reg <= '0;
      else
        idle_cnt_reg <= idle_cnt_reg + 20'd1;
    end
  end
`else
  assign launch = start;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic for the self-test sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (launch) state_next = ST_APPLY;
      ST_APPLY:   state_next = (SETTLE == 0) ? ST_COMPARE : ST_WAIT;
      ST_WAIT:    if (settle_cnt_reg == SETTLE_M1) state_next = ST_COMPARE;
      ST_COMPARE: state_next = last_pat ? ST_DECIDE : ST_APPLY;
      ST_DECIDE:  state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Fault mask to steering configuration; all-faulty keeps the current config.
  always_comb begin
    cfg_next = cfg_reg;
    case (mask_reg)
      3'b000:  cfg_next = CFG_000;
      3'b001:  cfg_next = CFG_001;
      3'b010:  cfg_next = CFG_010;
      3'b100:  cfg_next = CFG_100;
      3'b011:  cfg_next = CFG_011;
      3'b101:  cfg_next = CFG_101;
      3'b110:  cfg_next = CFG_110;
      3'b111:  cfg_next = cfg_reg;
      default: cfg_next = cfg_reg;
    endcase
  end

  // Registered outputs and run bookkeeping, updated per current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_idx_reg    <= '0;
      test_reg       <= 1'b0;
      test_data_reg  <= '0;
      settle_cnt_reg <= '0;
      mask_reg       <= '0;
      fault_reg      <= '0;
      cfg_reg        <= CFG_000;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            mask_reg      <= '0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b1;
            pat_idx_reg   <= '0;
            test_reg      <= 1'b1;
            test_data_reg <= '0;
          end
        end
        ST_APPLY: begin
          settle_cnt_reg <= '0;
        end
        ST_WAIT: begin
          settle_cnt_reg <= settle_cnt_reg + 4'd1;
        end
        ST_COMPARE: begin
          mask_reg <= mask_reg | miss;
          // Final pattern exits before the increment, so a 4-bit index never wraps.
          if (!last_pat) begin
            pat_idx_reg   <= pat_idx_reg + 4'd1;
            test_data_reg <= pat_idx_reg + 4'd1;
          end
        end
        ST_DECIDE: begin
          test_reg      <= 1'b0;
          test_data_reg <= '0;
          fault_reg     <= mask_reg;
          cfg_reg       <= cfg_next;
          if (mask_reg == 3'b111)
            err_reg <= 1'b1;
          done_reg      <= 1'b1;
        end
        ST_DONE: begin
          done_reg    <= 1'b0;
          busy_reg    <= 1'b0;
          pat_idx_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign pat_idx   = pat_idx_reg;
  assign test      = test_reg;
  assign test_data = test_data_reg;
  assign is0       = cfg_reg[13:11];
  assign is1       = cfg_reg[10:8];
  assign ss0       = cfg_reg[7:4];
  assign ss1       = cfg_reg[3:0];
  assign fault     = fault_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_csa_reconfig_ctrl.sv
// Testbench for csa_reconfig_ctrl: models the golden ROM and a datapath with
// per-unit stuck-at-1 injection on bit 0, then runs directed fault scenarios.
module tb_csa_reconfig_ctrl;

  localparam int NUM_PAT = 16;
  localparam int SETTLE  = 1;
  localparam int LAT     = NUM_PAT * (SETTLE + 2) + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [29:0] actual_output;
  logic [5:0]  exp_resp;
  logic [3:0]  pat_idx;
  logic        test;
  logic [3:0]  test_data;
  logic [2:0]  is0, is1;
  logic [3:0]  ss0, ss1;
  logic [2:0]  fault;
  logic        busy, done, err;
  logic [4:0]  force_units;

  int n_checks = 0;
  int n_fail   = 0;

  csa_reconfig_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .actual_output(actual_output), .exp_resp(exp_resp),
    .pat_idx(pat_idx), .test(test), .test_data(test_data),
    .is0(is0), .is1(is1), .ss0(ss0), .ss1(ss1),
    .fault(fault), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] gold(input logic [3:0] k);
    logic [5:0] t;
    t = {2'b00, k};
    return t * 6'd5 + 6'd3;
  endfunction

  // Golden ROM addressed by pat_idx.
  assign exp_resp = gold(pat_idx);

  // Datapath model: every unit answers gold(test_data); injected units stuck bit 0 at 1.
  always_comb begin
    actual_output = '0;
    for (int u = 0; u < 5; u++)
      actual_output[6*u +: 6] = gold(test_data) | (force_units[u] ? 6'h01 : 6'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [13:0] cfg_now();
    return {is0, is1, ss0, ss1};
  endfunction

  // One run: pulse start, measure latency, check results; optional stray start mid-run.
  task automatic run_row(input string name, input logic [4:0] units,
                         input logic [2:0] exp_fault, input logic [13:0] exp_cfg,
                         input logic exp_err, input bit stray_start);
    int n;
    bit seen_test;
    bit cfg_moved;
    logic [13:0] cfg_before;
    int extra_done;
    force_units = units;
    cfg_before  = cfg_now();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_busy_start"}, 32'(busy), 32'd1);
    chk({name, "_err_cleared"}, 32'(err), 32'd0);
    n = 1;
    seen_test = 1'b0;
    cfg_moved = 1'b0;
    while (!done && n < 200) begin
      if (test) seen_test = 1'b1;
      if (cfg_now() != cfg_before) cfg_moved = 1'b1;
      if (stray_start && n == 20) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(LAT));
    chk({name, "_test_seen"}, 32'(seen_test), 32'd1);
    chk({name, "_cfg_held"}, 32'(cfg_moved), 32'd0);
    chk({name, "_fault"}, 32'(fault), 32'(exp_fault));
    chk({name, "_cfg"}, 32'(cfg_now()), 32'(exp_cfg));
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    chk({name, "_test_off"}, 32'(test), 32'd0);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    if (stray_start) begin
      extra_done = 0;
      for (int i = 0; i < 60; i++) begin
        if (done || busy) extra_done++;
        @(posedge clk); #1;
      end
      chk({name, "_no_extra_run"}, 32'(extra_done), 32'd0);
    end
    $display("run %s: fault=%b cfg=%h err=%b latency=%0d", name, fault, cfg_now(), err, n);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_test"}, 32'(test), 32'd0);
    chk({name, "_test_data"}, 32'(test_data), 32'd0);
    chk({name, "_pat_idx"}, 32'(pat_idx), 32'd0);
    chk({name, "_cfg"}, 32'(cfg_now()), 32'h3F00);
    chk({name, "_fault"}, 32'(fault), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    force_units = 5'b00000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (6) @(posedge clk);

    //       name           units      fault   cfg        err  stray
    run_row("healthy",     5'b00000, 3'b000, 14'h3F00, 1'b0, 1'b0);
    run_row("u2_stuck",    5'b00100, 3'b010, 14'h2E33, 1'b0, 1'b0);
    run_row("u1_ignored",  5'b00010, 3'b000, 14'h3F00, 1'b0, 1'b0);
    run_row("u0_u4",       5'b10001, 3'b101, 14'h1C7F, 1'b0, 1'b0);
    run_row("healthy2",    5'b00000, 3'b000, 14'h3F00, 1'b0, 1'b1);
    run_row("u0",          5'b00001, 3'b001, 14'h1F11, 1'b0, 1'b0);
    run_row("u4_u3",       5'b11000, 3'b100, 14'h3C77, 1'b0, 1'b0);
    run_row("u0_u2",       5'b00101, 3'b011, 14'h0E3B, 1'b0, 1'b0);
    run_row("u2_u4",       5'b10100, 3'b110, 14'h2C7E, 1'b0, 1'b0);
    run_row("all_three",   5'b10101, 3'b111, 14'h2C7E, 1'b1, 1'b0);
    run_row("recover",     5'b00000, 3'b000, 14'h3F00, 1'b0, 1'b0);
    run_row("u0_again",    5'b00001, 3'b001, 14'h1F11, 1'b0, 1'b0);

    // Reset in the middle of a run, at pattern 7.
    force_units = 5'b00100;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (pat_idx != 4'd7 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_reach_pat7", 32'(pat_idx), 32'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("midrst");
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (done || busy) n++;
      @(posedge clk); #1;
    end
    chk("midrst_no_resume", 32'(n), 32'd0);
    $display("midrst: cfg=%h fault=%b busy=%b", cfg_now(), fault, busy);

    // Start coincident with reset: reset wins, no run begins.
    start = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_test", 32'(test), 32'd0);
    $display("rst_start: busy=%b test=%b", busy, test);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
